int_sync_crossing_sink: RTL and testbench

INT_SYNC_CROSSING_SINK -- requirements
Module: int_sync_crossing_sink

---
 rtl/int_sync_pkg.sv | 14 +
 rtl/int_sync_shift_reg.sv | 30 +++
 rtl/int_sync_crossing_sink.sv | 68 ++++++
 tb/tb_int_sync_crossing_sink.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/int_sync_pkg.sv
// Shared defaults and helpers for the interrupt crossing sink.
// Counter sizing lives here so every user agrees on it.
package int_sync_pkg;

  localparam int SYNC_DEPTH_DEFAULT    = 3;
  localparam int FILTER_CYCLES_DEFAULT = 0;

  function automatic int cnt_width(input int filter_cycles);
    int w;
    w = $clog2(filter_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/int_sync_shift_reg.sv
// Single-bit synchronizer chain with synchronous reset.
// q is the last flop of the chain.
module int_sync_shift_reg #(
  parameter int DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clock) begin
        if (reset) chain <= '0;
        else       chain <= d;
      end
    end else begin : g_many
      always_ff @(posedge clock) begin
        if (reset) chain <= '0;
        else       chain <= {chain[DEPTH-2:0], d};
      end
    end
  endgenerate

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/int_sync_crossing_sink.sv
// Interrupt crossing sink: per-bit synchronizer plus stability filter.
// Outputs change only after the synchronized level holds long enough.
module int_sync_crossing_sink
  import int_sync_pkg::*;
#(
  parameter int SYNC_DEPTH    = SYNC_DEPTH_DEFAULT,
  parameter int FILTER_CYCLES = FILTER_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic auto_in_sync_0,
  input  logic auto_in_sync_1,
  output logic auto_out_0,
  output logic auto_out_1
);

  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES);

  logic s_0;
  logic s_1;
  logic [CW-1:0] cnt_0;
  logic [CW-1:0] cnt_1;

  int_sync_shift_reg #(.DEPTH(SYNC_DEPTH)) u_sync_0 (
    .clock (clock),
    .reset (reset),
    .d     (auto_in_sync_0),
    .q     (s_0)
  );

  int_sync_shift_reg #(.DEPTH(SYNC_DEPTH)) u_sync_1 (
    .clock (clock),
    .reset (reset),
    .d     (auto_in_sync_1),
    .q     (s_1)
  );

  // Any return to the current output level restarts the count.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_0      <= '0;
      auto_out_0 <= 1'b0;
    end else if (s_0 == auto_out_0) begin
      cnt_0 <= '0;
    end else if (cnt_0 == CNT_MAX) begin
      cnt_0      <= '0;
      auto_out_0 <= s_0;
    end else begin
      cnt_0 <= cnt_0 + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_1      <= '0;
      auto_out_1 <= 1'b0;
    end else if (s_1 == auto_out_1) begin
      cnt_1 <= '0;
    end else if (cnt_1 == CNT_MAX) begin
      cnt_1      <= '0;
      auto_out_1 <= s_1;
    end else begin
      cnt_1 <= cnt_1 + CW'(1);
    end
  end

endmodule

// File: tb/tb_int_sync_crossing_sink.sv
// Directed bench: one sink unfiltered (F=0), one filtered (F=2).
// Edge counts are relative to the first edge that samples new input.
module tb_int_sync_crossing_sink;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic a_in0 = 1'b0;
  logic a_in1 = 1'b0;
  logic b_in0 = 1'b0;
  logic b_in1 = 1'b0;
  logic a_out0, a_out1;
  logic b_out0, b_out1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  int_sync_crossing_sink #(.SYNC_DEPTH(3), .FILTER_CYCLES(0)) dut_f0 (
    .clock          (clock),
    .reset          (reset),
    .auto_in_sync_0 (a_in0),
    .auto_in_sync_1 (a_in1),
    .auto_out_0     (a_out0),
    .auto_out_1     (a_out1)
  );

  int_sync_crossing_sink #(.SYNC_DEPTH(3), .FILTER_CYCLES(2)) dut_f2 (
    .clock          (clock),
    .reset          (reset),
    .auto_in_sync_0 (b_in0),
    .auto_in_sync_1 (b_in1),
    .auto_out_0     (b_out0),
    .auto_out_1     (b_out1)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_in0 = 1'b0; a_in1 = 1'b0;
    b_in0 = 1'b0; b_in1 = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_a_out0", a_out0, 0);
    check("rst_a_out1", a_out1, 0);
    check("rst_b_out0", b_out0, 0);
    check("rst_b_out1", b_out1, 0);
    check("rst_b_cnt0", dut_f2.cnt_0, 0);
    reset = 1'b0;

    // Test 1: F=0, rise seen after edge 4
    do_reset();
    a_in0 = 1'b1;
    tick(3);
    check("t1_e3_out0", a_out0, 0);
    check("t1_e3_out1", a_out1, 0);
    tick(1);
    check("t1_e4_out0", a_out0, 1);
    check("t1_e4_out1", a_out1, 0);
    tick(3);
    check("t1_hold_out0", a_out0, 1);
    check("t1_hold_out1", a_out1, 0);

    // Test 2: F=2, rise and fall both take 6 edges
    do_reset();
    b_in1 = 1'b1;
    tick(5);
    check("t2_e5_out1", b_out1, 0);
    tick(1);
    check("t2_e6_out1", b_out1, 1);
    check("t2_e6_out0", b_out0, 0);
    tick(2);
    b_in1 = 1'b0;
    tick(5);
    check("t2_fall_e5", b_out1, 1);
    tick(1);
    check("t2_fall_e6", b_out1, 0);

    // Test 3a: 2-cycle pulse is filtered out
    do_reset();
    b_in0 = 1'b1;
    tick(2);
    b_in0 = 1'b0;
    for (int i = 0; i < 8; i++) check("t3_short", b_out0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      check("t3_short_cyc", b_out0, 0);
    end

    // Test 3b: 3-cycle pulse gives exactly 3 high cycles
    do_reset();
    b_in0 = 1'b1;
    tick(3);
    b_in0 = 1'b0;
    tick(2);
    check("t3_e5", b_out0, 0);
    tick(1);
    check("t3_e6", b_out0, 1);
    tick(1);
    check("t3_e7", b_out0, 1);
    tick(1);
    check("t3_e8", b_out0, 1);
    tick(1);
    check("t3_e9", b_out0, 0);

    // Test 4: glitch restarts the count
    do_reset();
    b_in0 = 1'b1;
    tick(2);
    b_in0 = 1'b0;
    tick(1);
    b_in0 = 1'b1;
    tick(5);
    check("t4_e8", b_out0, 0);
    tick(1);
    check("t4_e9", b_out0, 1);

    // Test 5: reset mid-count discards everything
    do_reset();
    b_in0 = 1'b1;
    tick(4);
    check("t5_cnt1", dut_f2.cnt_0, 1);
    reset = 1'b1;
    tick(1);
    check("t5_rst_out0", b_out0, 0);
    check("t5_rst_cnt0", dut_f2.cnt_0, 0);
    check("t5_rst_s0", dut_f2.u_sync_0.q, 0);
    check("t5_rst_chain", dut_f2.u_sync_0.chain, 0);
    reset = 1'b0;
    tick(5);
    check("t5_post_e5", b_out0, 0);
    tick(1);
    check("t5_post_e6", b_out0, 1);

    // Test 6: opposite toggles on both bits
    do_reset();
    b_in0 = 1'b1;
    tick(6);
    check("t6_pre_out0", b_out0, 1);
    check("t6_pre_out1", b_out1, 0);
    b_in0 = 1'b0;
    b_in1 = 1'b1;
    tick(5);
    check("t6_e5_out0", b_out0, 1);
    check("t6_e5_out1", b_out1, 0);
    tick(1);
    check("t6_e6_out0", b_out0, 0);
    check("t6_e6_out1", b_out1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
